aes_block_loader: RTL and testbench
===================================

# aes_block_loader

Reads ciphertext bytes from port A of the QSPI-filled dual-port byte RAM and packs each 16-byte group into a 128-bit block for the AES inverse cipher. It sits between the RAM and `aes_inv_cipher_top`: it drives the RAM read address, assembles blocks MSB-first, pulses `ld`, and waits for the core's `done`. While the core decrypts one block, the loader prefetches the next one into a shadow register, so back-to-back blocks are loaded with no bubble.

## Interface
- `ADDR_W`, 8: RAM address width. Max blocks per frame = 2^(ADDR_W-4).
- `RD_LAT`, 1: RAM read latency in cycles (address in → `ram_data` valid). Legal values are 1 and 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock (50 MHz domain).
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: single-cycle pulse that starts a frame; already synchronous to `clk`.
- `num_blocks`  in  ADDR_W-3: number of blocks in the frame, 0..2^(ADDR_W-4). Sampled on `start`.
- `key_ready`  in  1: level; the key schedule is valid.
- `ram_addra`  out  ADDR_W: RAM port-A read address.
- `ram_data`  in  8: RAM port-A read data.
- `ld`  out  1: one-cycle load strobe to the AES core.
- `aes_data`  out  128: block presented to the AES core. Stable from `ld` until the next `ld`.
- `aes_done`  in  1: AES core done pulse.
- `busy`  out  1: high from the cycle after an accepted `start` until `frame_done`.
- `blk_idx`  out  ADDR_W-4: index of the block most recently loaded.
- `frame_done`  out  1: one-cycle pulse when the last block's `aes_done` is seen.

## Operation
- **Reset values:** all outputs 0. FSM in `IDLE`. Byte counter, block counters and shadow-valid flag cleared.
- **FSM states:** `IDLE`, `FETCH`, `DRAIN`, `WAIT_KEY`, `LOAD`, `WAIT_AES`.
- **IDLE:**
  - `start` with `num_blocks`=0: `frame_done` pulses next cycle; `busy` stays 0.
  - `start` with `num_blocks`>0: latch `num_blocks`, set base address 0, go to `FETCH`.
- **FETCH:** issue 16 consecutive addresses (base+0 .. base+15), one per cycle. Byte k (address base+k) is written into shadow bits [127-8k -: 8] when it returns, RD_LAT cycles later.
- **DRAIN:** wait for the last byte. Then set shadow-valid and advance base by 16.
- **WAIT_KEY:** wait until `key_ready`=1, then go to `LOAD`.
- **LOAD:** copy shadow → `aes_data`, pulse `ld`, update `blk_idx`, clear shadow-valid.
  - If blocks remain to be fetched, start prefetching the next block in parallel (FETCH/DRAIN sub-sequencer).
  - Go to `WAIT_AES`.
- **WAIT_AES:** on `aes_done`:
  - If this was the last block: pulse `frame_done`, go to `IDLE`.
  - Otherwise, if shadow-valid: go to `WAIT_KEY` (a zero-wait pass when `key_ready`=1).
  - Otherwise: keep waiting for the prefetch to finish, then go to `WAIT_KEY`.
- **Ignored inputs:**
  - `start` while `busy`.
  - `aes_done` outside `WAIT_AES`.
- **`key_ready` falling mid-frame:** no effect on a block already loaded. The next `ld` is held in `WAIT_KEY`.
- **Address wrap:** the address counter is ADDR_W bits. A full-size frame ends at address 2^ADDR_W-1; no wrap occurs within a frame.
- **Reset mid-frame:** immediate abort to reset values. No `frame_done` is issued.

## Timing
- Let `start` be sampled at edge T, with `key_ready`=1.
  - `ram_addra` = 0..15 during cycles T+1..T+16.
  - Last byte captured at T+16+RD_LAT.
  - `ld` high in cycle T+17+RD_LAT, i.e. 18 cycles after `start` for RD_LAT=1.
- `aes_data` changes only in the same cycle `ld` goes high.
- **Prefetch timing:**
  - The next block's fetch starts in the cycle after `ld`.
  - Shadow-valid is set 17+RD_LAT cycles after `ld`.
  - If `aes_done` arrives later than that, the next `ld` is exactly 2 cycles after `aes_done` (WAIT_AES → WAIT_KEY → LOAD).
- `frame_done` is high in the cycle after the final `aes_done` is sampled. `busy` falls in that same cycle.
- `ram_addra` holds its last value when not fetching.

## Structure
- Shared package `aes_pkg`:
  - `BLOCK_BYTES`=16, `BLOCK_W`=128.
  - FSM state encoding typedef.
  - Byte-lane helper function: byte k → bit slice.
- Natural sub-module `byte_packer`: address counter, RD_LAT-deep valid pipe, and 128-bit shadow shifter. Controlled by `fetch_go` / `pack_done`. The top module keeps the FSM, block counters and `aes_data` register.

## Test plan
- Reset with `start` held high → all outputs 0, no `ld`; after reset release, a fresh `start` operates normally.
- RAM[0..15]=0x00..0x0F, `num_blocks`=1, `key_ready`=1, `aes_done` 20 cycles after `ld` → `aes_data`=0x000102…0F, `ld` at start+18, `frame_done` at the cycle after `aes_done`.
- `num_blocks`=3, `aes_done` 50 cycles after each `ld` → three `ld` pulses; the 2nd and 3rd come 2 cycles after `aes_done`; `blk_idx` = 0, 1, 2; blocks match RAM[0..47].
- `key_ready`=0 at `start`, raised 100 cycles later → first `ld` 2 cycles after the rise; `aes_data` correct.
- `num_blocks`=0 → `frame_done` one cycle after `start`, `busy` never high, no `ld`; a second `start` while `busy` (in another frame) is ignored.
- Async reset asserted during `WAIT_AES` of block 1 of 4 → outputs 0 immediately, no `frame_done`; next frame starts from address 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES ciphertext block loader.
package aes_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = 128;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_KEY,
        LOAD,
        WAIT_AES
    } state_e;

    // LSB position of byte k in an MSB-first packed block
    function automatic int unsigned byte_lane(input logic [3:0] k);
        return BLOCK_W - 8 - 8 * 32'(k);
    endfunction

endpackage

// File: rtl/aes_block_loader_byte_packer.sv
// Issues 16 consecutive RAM reads and packs the returning bytes MSB-first into a shadow block.
module byte_packer
    import aes_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_go,
    input  logic [ADDR_W-1:0]  base,
    input  logic [7:0]         ram_data,
    output logic [ADDR_W-1:0]  ram_addra,
    output logic               issue_last_c,
    output logic               pack_done,
    output logic [BLOCK_W-1:0] block_c
);

    logic               issuing;
    logic [3:0]         issue_cnt;
    logic [3:0]         wr_cnt;
    logic [RD_LAT-1:0]  vld_pipe;
    logic [RD_LAT-1:0]  last_pipe;
    logic [BLOCK_W-1:0] shadow;
    logic               data_vld;

    assign issue_last_c = issuing && (issue_cnt == 4'd15);
    assign data_vld     = vld_pipe[RD_LAT-1];
    assign pack_done    = last_pipe[RD_LAT-1];

    // Address sequencer; the address holds its last value once the burst ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addra <= '0;
            issuing   <= 1'b0;
            issue_cnt <= '0;
        end else if (fetch_go) begin
            ram_addra <= base;
            issuing   <= 1'b1;
            issue_cnt <= '0;
        end else if (issuing) begin
            if (issue_last_c) begin
                issuing <= 1'b0;
            end else begin
                ram_addra <= ram_addra + ADDR_W'(1);
                issue_cnt <= issue_cnt + 4'd1;
            end
        end
    end

    // Read-latency pipe marking which cycles carry valid (and final) RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            vld_pipe[0]  <= issuing;
            last_pipe[0] <= issue_last_c;
        end
    end

    // Shadow contents including the byte arriving this cycle
    always_comb begin
        block_c = shadow;
        if (data_vld) begin
            block_c[byte_lane(wr_cnt) +: 8] = ram_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            wr_cnt <= '0;
        end else if (fetch_go) begin
            wr_cnt <= '0;
        end else if (data_vld) begin
            shadow <= block_c;
            wr_cnt <= wr_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Feeds 128-bit ciphertext blocks from the byte RAM to the AES inverse cipher,
// prefetching the next block while the core works on the current one.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-4:0]  num_blocks,
    input  logic               key_ready,
    output logic [ADDR_W-1:0]  ram_addra,
    input  logic [7:0]         ram_data,
    output logic               ld,
    output logic [BLOCK_W-1:0] aes_data,
    input  logic               aes_done,
    output logic               busy,
    output logic [ADDR_W-5:0]  blk_idx,
    output logic               frame_done
);

    localparam int unsigned CNT_W = ADDR_W - 3;
    localparam int unsigned IDX_W = ADDR_W - 4;

    state_e             state;
    state_e             state_nxt;
    logic [CNT_W-1:0]   nblk;
    logic [CNT_W-1:0]   fetch_cnt;
    logic [CNT_W-1:0]   ld_cnt;
    logic [ADDR_W-1:0]  base;
    logic               shadow_valid;
    logic               done_seen;
    logic               key_q;
    logic               fetch_go_c;
    logic               frame_done_nxt;
    logic               last_blk_c;
    logic               issue_last_c;
    logic               pack_done;
    logic [BLOCK_W-1:0] block_c;

    byte_packer #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_go     (fetch_go_c),
        .base         (base),
        .ram_data     (ram_data),
        .ram_addra    (ram_addra),
        .issue_last_c (issue_last_c),
        .pack_done    (pack_done),
        .block_c      (block_c)
    );

    assign last_blk_c = (ld_cnt == nblk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DRAIN goes straight to LOAD when the key is ready, so the first ld needs no extra cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && (num_blocks != '0)) state_nxt = FETCH;
            FETCH:    if (issue_last_c) state_nxt = DRAIN;
            DRAIN:    if (pack_done) state_nxt = key_q ? LOAD : WAIT_KEY;
            WAIT_KEY: if (key_q) state_nxt = LOAD;
            LOAD:     state_nxt = WAIT_AES;
            WAIT_AES: begin
                if (aes_done && last_blk_c) begin
                    state_nxt = IDLE;
                end else if ((aes_done || done_seen) && shadow_valid) begin
                    state_nxt = WAIT_KEY;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_go_c     = 1'b0;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                fetch_go_c     = start && (num_blocks != '0);
                frame_done_nxt = start && (num_blocks == '0);
            end
            LOAD:     fetch_go_c     = (fetch_cnt < nblk);
            WAIT_AES: frame_done_nxt = aes_done && last_blk_c;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld           <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            aes_data     <= '0;
            blk_idx      <= '0;
            nblk         <= '0;
            fetch_cnt    <= '0;
            ld_cnt       <= '0;
            base         <= '0;
            shadow_valid <= 1'b0;
            done_seen    <= 1'b0;
            key_q        <= 1'b0;
        end else begin
            ld         <= (state_nxt == LOAD);
            busy       <= (state_nxt != IDLE);
            frame_done <= frame_done_nxt;
            key_q      <= key_ready;
            done_seen  <= (state == WAIT_AES) && (state_nxt == WAIT_AES) && (aes_done || done_seen);

            if ((state == IDLE) && start) begin
                nblk <= num_blocks;
            end
            if (fetch_go_c) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
                base      <= base + ADDR_W'(BLOCK_BYTES);
            end
            if (state_nxt == LOAD) begin
                aes_data     <= block_c;
                blk_idx      <= ld_cnt[IDX_W-1:0];
                ld_cnt       <= ld_cnt + CNT_W'(1);
                shadow_valid <= 1'b0;
            end else if (pack_done) begin
                shadow_valid <= 1'b1;
            end
            // Frame end rewinds the counters so the next frame reads from address 0
            if (frame_done_nxt) begin
                fetch_cnt <= '0;
                ld_cnt    <= '0;
                base      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with a registered 1-cycle-latency byte RAM model.
module tb_aes_block_loader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [4:0]   num_blocks;
    logic         key_ready;
    logic [7:0]   ram_addra;
    logic [7:0]   ram_data;
    logic         ld;
    logic [127:0] aes_data;
    logic         aes_done;
    logic         busy;
    logic [3:0]   blk_idx;
    logic         frame_done;

    logic [7:0]   mem [256];
    logic [127:0] exp_blk [3];

    int cyc = 0;
    int n_ld = 0;
    int n_fd = 0;
    int n_busy = 0;
    int checks = 0;
    int errors = 0;
    int at, c0, d0, r0, base_ld, base_fd, base_busy;

    aes_block_loader #(
        .ADDR_W (8),
        .RD_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_blocks (num_blocks),
        .key_ready  (key_ready),
        .ram_addra  (ram_addra),
        .ram_data   (ram_data),
        .ld         (ld),
        .aes_data   (aes_data),
        .aes_done   (aes_done),
        .busy       (busy),
        .blk_idx    (blk_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_data <= mem[ram_addra];
        if (ld === 1'b1)         n_ld   <= n_ld + 1;
        if (frame_done === 1'b1) n_fd   <= n_fd + 1;
        if (busy === 1'b1)       n_busy <= n_busy + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ld(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ld === 1'b1) begin
                when = cyc;
                return;
            end
        end
    endtask

    task automatic pulse_done();
        aes_done = 1'b1;
        d0 = cyc;
        @(negedge clk);
        aes_done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        exp_blk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        exp_blk[1] = 128'h101112131415161718191a1b1c1d1e1f;
        exp_blk[2] = 128'h202122232425262728292a2b2c2d2e2f;

        // Reset held with start asserted
        rst_n = 1'b0; start = 1'b1; num_blocks = 5'd1; key_ready = 1'b1; aes_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ld", 128'(ld), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_frame_done", 128'(frame_done), 128'(0));
        chk("rst_aes_data", aes_data, 128'(0));
        chk("rst_addr", 128'(ram_addra), 128'(0));
        chk("rst_blk_idx", 128'(blk_idx), 128'(0));
        chk("rst_no_ld", 128'(n_ld), 128'(0));
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single block
        c0 = cyc; base_fd = n_fd; start = 1'b1; num_blocks = 5'd1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy_rise", 128'(busy), 128'(1));
        repeat (4) @(negedge clk);
        chk("t1_addr4", 128'(ram_addra), 128'(4));
        repeat (11) @(negedge clk);
        chk("t1_addr15", 128'(ram_addra), 128'(15));
        wait_ld(10, at);
        chk("t1_ld_time", 128'(at), 128'(c0 + 18));
        chk("t1_data", aes_data, exp_blk[0]);
        chk("t1_blk_idx", 128'(blk_idx), 128'(0));
        repeat (20) @(negedge clk);
        pulse_done();
        chk("t1_frame_done", 128'(frame_done), 128'(1));
        chk("t1_busy_fall", 128'(busy), 128'(0));
        @(negedge clk);
        chk("t1_frame_done_pulse", 128'(frame_done), 128'(0));
        chk("t1_fd_count", 128'(n_fd - base_fd), 128'(1));
        repeat (3) @(negedge clk);

        // Empty frame
        base_ld = n_ld; base_busy = n_busy; base_fd = n_fd;
        c0 = cyc; start = 1'b1; num_blocks = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t0_frame_done", 128'(frame_done), 128'(1));
        chk("t0_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("t0_frame_done_pulse", 128'(frame_done), 128'(0));
        repeat (5) @(negedge clk);
        chk("t0_no_ld", 128'(n_ld - base_ld), 128'(0));
        chk("t0_no_busy", 128'(n_busy - base_busy), 128'(0));
        chk("t0_fd_count", 128'(n_fd - base_fd), 128'(1));

        // Three blocks with prefetch; a start while busy is ignored
        base_ld = n_ld; base_fd = n_fd;
        c0 = cyc; start = 1'b1; num_blocks = 5'd3;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            wait_ld((b == 0) ? 25 : 10, at);
            chk("t3_ld_time", 128'(at), 128'((b == 0) ? c0 + 18 : d0 + 2));
            chk("t3_data", aes_data, exp_blk[b]);
            chk("t3_blk_idx", 128'(blk_idx), 128'(b));
            for (int i = 1; i <= 50; i++) begin
                @(negedge clk);
                if (b == 0 && i == 1) chk("t3_prefetch_addr", 128'(ram_addra), 128'(16));
                if (b == 0 && i == 5) begin start = 1'b1; num_blocks = 5'd0; end
                if (b == 0 && i == 6) start = 1'b0;
            end
            pulse_done();
            chk("t3_frame_done", 128'(frame_done), 128'((b == 2) ? 1 : 0));
        end
        @(negedge clk);
        chk("t3_ld_count", 128'(n_ld - base_ld), 128'(3));
        chk("t3_fd_count", 128'(n_fd - base_fd), 128'(1));
        chk("t3_addr_hold", 128'(ram_addra), 128'(47));
        chk("t3_busy_idle", 128'(busy), 128'(0));

        // Key not ready at start
        base_ld = n_ld;
        key_ready = 1'b0;
        start = 1'b1; num_blocks = 5'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("tk_held", 128'(n_ld - base_ld), 128'(0));
        r0 = cyc; key_ready = 1'b1;
        wait_ld(10, at);
        chk("tk_ld_time", 128'(at), 128'(r0 + 2));
        chk("tk_data", aes_data, exp_blk[0]);
        repeat (5) @(negedge clk);
        pulse_done();
        chk("tk_frame_done", 128'(frame_done), 128'(1));
        repeat (3) @(negedge clk);

        // Reset during WAIT_AES of block 1 of 4
        base_fd = n_fd;
        c0 = cyc; start = 1'b1; num_blocks = 5'd4;
        @(negedge clk);
        start = 1'b0;
        wait_ld(25, at);
        chk("tr_ld0_time", 128'(at), 128'(c0 + 18));
        repeat (20) @(negedge clk);
        pulse_done();
        wait_ld(10, at);
        chk("tr_ld1_time", 128'(at), 128'(d0 + 2));
        chk("tr_blk_idx1", 128'(blk_idx), 128'(1));
        chk("tr_data1", aes_data, exp_blk[1]);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("tr_ld", 128'(ld), 128'(0));
        chk("tr_busy", 128'(busy), 128'(0));
        chk("tr_aes_data", aes_data, 128'(0));
        chk("tr_blk_idx", 128'(blk_idx), 128'(0));
        chk("tr_addr", 128'(ram_addra), 128'(0));
        chk("tr_frame_done", 128'(frame_done), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("tr_no_fd", 128'(n_fd - base_fd), 128'(0));

        c0 = cyc; start = 1'b1; num_blocks = 5'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("tr_new_addr4", 128'(ram_addra), 128'(4));
        wait_ld(20, at);
        chk("tr_new_ld_time", 128'(at), 128'(c0 + 18));
        chk("tr_new_data", aes_data, exp_blk[0]);
        repeat (20) @(negedge clk);
        pulse_done();
        chk("tr_new_frame_done", 128'(frame_done), 128'(1));
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
